serial_sum_collector: RTL
=========================

Name: serial_sum_collector

Overview:
Downstream stage of the bit-serial adder. It captures the sum bit and carry-out that the adder produces each cycle, LSB first, and assembles them into a parallel WIDTH-bit result. It also provides the final carry-out and the signed-overflow flag. The result is presented on a valid/ready handshake to the consumer, such as a register file or display logic.

Parameters:
WIDTH, 4, operand/result width in bits; number of serial bits per word (legal range ≥2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin collecting a new word; aborts a word in progress
bit_valid  input  1  s_in/c_in carry a valid bit this cycle
s_in  input  1  sum bit of current position (LSB first)
c_in  input  1  carry-out of current bit position
sum  output  WIDTH  assembled sum, sum[0] = first bit received
cout  output  1  carry-out of bit WIDTH-1
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
out_valid  output  1  result held and valid
out_ready  input  1  consumer accepts result
busy  output  1  high in COLLECT state
overrun  output  1  sticky; a bit_valid arrived while a result was held

Behaviour:
- Reset (async, rst=1): state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, overrun=0, bit counter=0, internal shift register=0, prev-carry=0.
- States:
  - IDLE: bit_valid ignored.
  - COLLECT: busy=1.
  - HOLD: out_valid=1.
- IDLE, start=1 → COLLECT. Counter=0, shift register cleared, overrun cleared.
- COLLECT, bit_valid=1:
  - Shift register shifts right; s_in enters bit WIDTH-1. After WIDTH bits, the first bit received sits at bit 0.
  - Counter increments.
  - c_in is stored as prev-carry.
- COLLECT, on the bit where counter==WIDTH-1:
  - sum ← shifted value including this bit.
  - cout ← c_in.
  - ovf ← prev-carry XOR c_in.
  - Next state HOLD.
  - out_valid rises on the next cycle: one-cycle latency after the last bit is sampled.
- COLLECT, bit_valid=0: hold all state; there is no timeout.
- COLLECT, start=1 (with or without bit_valid): restart. Counter=0, shift register cleared, the bit in that cycle is discarded, state stays COLLECT.
- HOLD:
  - sum/cout/ovf stay stable while out_valid=1 and out_ready=0.
  - Handshake completes on the edge where out_valid=1 and out_ready=1.
  - On completion, out_valid=0 the next cycle. Next state is COLLECT if start=1 in the same cycle (back-to-back, overrun cleared), otherwise IDLE.
  - sum/cout/ovf keep their last values after the handshake until the next word completes.
- HOLD, start=1 without out_ready: start is ignored and the result is not lost.
- HOLD, bit_valid=1: the bit is dropped and overrun←1. overrun is sticky until reset or an accepted start.
- Counter width: clog2(WIDTH+1); never exceeds WIDTH-1 in COLLECT.
- Reset mid-COLLECT or mid-HOLD: immediate return to reset values. A partial word is discarded.

Test Plan:
- Reset then 5+3, cin=0, WIDTH=4. start; bits (s,c) LSB first = (0,1),(0,1),(0,1),(1,0) on 4 consecutive cycles → out_valid the cycle after the 4th bit, sum=4'b1000, cout=0, ovf=1, busy 1→0.
- 15+1: bits (0,1),(0,1),(0,1),(0,1) → sum=0, cout=1, ovf=0. Hold out_ready=0 for 5 cycles → outputs stable, out_valid stays 1. Assert out_ready → out_valid=0 next cycle, state IDLE.
- Gapped input: same 5+3 stream with bit_valid low for 2 cycles between each bit → identical result (8, cout 0, ovf 1).
- Abort: start, 2 bits, start again, then stream for 7+7 = (0,1),(1,1),(1,1),(1,0) → sum=4'b1110, cout=0, ovf=1. Partial bits have no effect.
- Overrun and back-to-back: in HOLD, pulse bit_valid → overrun=1, sum unchanged. Then out_ready=1 with start=1 → out_valid=0, busy=1, overrun=0 next cycle; the next 4 bits produce a correct new word.
- Async reset asserted between clock edges mid-COLLECT → all outputs 0 immediately, before the next clk edge. After release, bit_valid alone has no effect until start.

Source files
------------

// File: rtl/serial_sum_collector.sv
// Assembles LSB-first sum/carry bits from a bit-serial adder into a parallel word
// with final carry-out and signed-overflow, presented on a valid/ready handshake.
module serial_sum_collector #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             s_in,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_HOLD    = 2'd2;
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic             prev_c;

   assign shifted   = {s_in, shreg[WIDTH-1:1]};
   assign out_valid = (state == S_HOLD);
   assign busy      = (state == S_COLLECT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         shreg   <= '0;
         prev_c  <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_COLLECT;
                  cnt     <= '0;
                  shreg   <= '0;
                  prev_c  <= 1'b0;
                  overrun <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (start) begin
                  // restart discards any partial word and the bit in this cycle
                  cnt     <= '0;
                  shreg   <= '0;
                  prev_c  <= 1'b0;
                  overrun <= 1'b0;
               end else if (bit_valid) begin
                  shreg  <= shifted;
                  prev_c <= c_in;
                  if (cnt == LAST) begin
                     // prev_c is the carry into the MSB
                     sum   <= shifted;
                     cout  <= c_in;
                     ovf   <= prev_c ^ c_in;
                     cnt   <= '0;
                     state <= S_HOLD;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_HOLD: begin
               if (out_ready && start) begin
                  state   <= S_COLLECT;
                  cnt     <= '0;
                  shreg   <= '0;
                  prev_c  <= 1'b0;
                  overrun <= 1'b0;
               end else begin
                  if (out_ready) state <= S_IDLE;
                  if (bit_valid) overrun <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
